doy_to_date: RTL and testbench

- Iterative converter from day-of-year (1..365) to calendar month (1..12) and day-of-month (1..31).
- It is the inverse of the month-length lookup used by the clock's date counters.
- Used when the clock is preset or synchronised by a day-of-year value, for example from a serial load path.
- Walks months sequentially, subtracting each month's length. Latency is 1 to 12 cycles.

---
 rtl/clock_date_pkg.sv | 30 +++
 rtl/month_len_rom.sv | 20 ++
 rtl/doy_to_date.sv | 113 +++++++++++
 tb/tb_doy_to_date.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/clock_date_pkg.sv
// Shared date constants, month encodings and converter FSM states.
// Pure declarations; used by the date counters and the day-of-year converter.
package clock_date_pkg;

    localparam int MONTH_W = 4;
    localparam int DAY_W   = 5;
    localparam int DOY_W   = 9;

    localparam logic [MONTH_W-1:0] JAN = 4'd1;
    localparam logic [MONTH_W-1:0] FEB = 4'd2;
    localparam logic [MONTH_W-1:0] MAR = 4'd3;
    localparam logic [MONTH_W-1:0] APR = 4'd4;
    localparam logic [MONTH_W-1:0] MAY = 4'd5;
    localparam logic [MONTH_W-1:0] JUN = 4'd6;
    localparam logic [MONTH_W-1:0] JUL = 4'd7;
    localparam logic [MONTH_W-1:0] AUG = 4'd8;
    localparam logic [MONTH_W-1:0] SEP = 4'd9;
    localparam logic [MONTH_W-1:0] OCT = 4'd10;
    localparam logic [MONTH_W-1:0] NOV = 4'd11;
    localparam logic [MONTH_W-1:0] DEC = 4'd12;

    localparam logic [DAY_W-1:0] FEB_DAYS      = 5'd28;
    localparam logic [DAY_W-1:0] FEB_DAYS_LEAP = 5'd29;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

endpackage

// File: rtl/month_len_rom.sv
// Combinational month-length table, zero latency, no flow control.
// Unknown month indices report 31 days so callers never see a zero length.
module month_len_rom
    import clock_date_pkg::*;
(
    input  logic [MONTH_W-1:0] month,
    input  logic               leap,
    output logic [DAY_W-1:0]   dim
);

    always_comb begin
        dim = 5'd31;
        case (month)
            FEB:                dim = leap ? FEB_DAYS_LEAP : FEB_DAYS;
            APR, JUN, SEP, NOV: dim = 5'd30;
            default:            dim = 5'd31;
        endcase
    end

endmodule

// File: rtl/doy_to_date.sv
// Day-of-year to month/day converter, 1..12 cycles (month number); starts while busy are dropped.
// Optional leap-year support under DOY_LEAP_YEAR_EN adds the leap_year input.
module doy_to_date
    import clock_date_pkg::*;
#(
    parameter int DOY_W   = 9,
    parameter int MAX_DOY = 365
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [DOY_W-1:0]   day_of_year,
`ifdef DOY_LEAP_YEAR_EN
    input  logic               leap_year,
`endif
    output logic               busy,
    output logic               done,
    output logic [MONTH_W-1:0] month,
    output logic [DAY_W-1:0]   day,
    output logic               err
);

    state_t             state, state_nxt;
    logic [DOY_W-1:0]   rem;
    logic [MONTH_W-1:0] cur_month;
    logic [DAY_W-1:0]   dim;
    logic [DOY_W-1:0]   dim_ext;
    logic               leap_q;
    logic               legal;
    logic               last_month;

`ifdef DOY_LEAP_YEAR_EN
    always_comb begin
        legal = (day_of_year != '0) &&
                ({23'd0, day_of_year} <= (leap_year ? MAX_DOY + 1 : MAX_DOY));
    end
`else
    always_comb begin
        legal = (day_of_year != '0) && ({23'd0, day_of_year} <= MAX_DOY);
    end
`endif

    month_len_rom u_rom (
        .month (cur_month),
        .leap  (leap_q),
        .dim   (dim)
    );

    assign dim_ext    = {{(DOY_W-DAY_W){1'b0}}, dim};
    assign last_month = (rem <= dim_ext);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && legal) state_nxt = CALC;
            CALC:    if (last_month)     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == CALC);

    // Datapath: rem walks down by each month length until it fits inside one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem       <= '0;
            cur_month <= '0;
            leap_q    <= 1'b0;
            done      <= 1'b0;
            month     <= '0;
            day       <= '0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && legal) begin
                        rem       <= day_of_year;
                        cur_month <= JAN;
                        err       <= 1'b0;
`ifdef DOY_LEAP_YEAR_EN
                        leap_q    <= leap_year;
`else
                        leap_q    <= 1'b0;
`endif
                    end else if (start) begin
                        err   <= 1'b1;
                        month <= '0;
                        day   <= '0;
                        done  <= 1'b1;
                    end
                end
                CALC: begin
                    if (last_month) begin
                        month <= cur_month;
                        day   <= rem[DAY_W-1:0];
                        done  <= 1'b1;
                    end else begin
                        rem       <= rem - dim_ext;
                        cur_month <= cur_month + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_doy_to_date.sv
// Scoreboarded bench for doy_to_date: directed vectors push expected results,
// a negedge monitor pops and compares whenever done pulses.
module tb_doy_to_date;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [8:0] day_of_year = '0;
`ifdef DOY_LEAP_YEAR_EN
    logic       leap_year = 1'b0;
`endif
    logic       busy, done, err;
    logic [3:0] month;
    logic [4:0] day;

    doy_to_date dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .day_of_year (day_of_year),
`ifdef DOY_LEAP_YEAR_EN
        .leap_year   (leap_year),
`endif
        .busy        (busy),
        .done        (done),
        .month       (month),
        .day         (day),
        .err         (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int m;
        int d;
        int e;
        int c;
    } exp_t;

    exp_t q[$];
    exp_t got;
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input int act, input int expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && done) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                got = q.pop_front();
                chk("month", int'(month), got.m);
                chk("day", int'(day), got.d);
                chk("err", int'(err), got.e);
                chk("done_cycle", cyc, got.c);
                chk("busy_with_done", int'(busy), 0);
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 50 && busy; i++) @(negedge clk);
    endtask

    task automatic wait_result();
        int n;
        n = 0;
        while (q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            chk("result_timeout", 1, 0);
            q.delete();
        end
    endtask

    task automatic issue(input int doy, input bit lp, input int m, input int d,
                         input int e, input int lat);
        exp_t x;
        @(negedge clk);
        wait_idle();
        x.m = m; x.d = d; x.e = e; x.c = cyc + 1 + lat;
        q.push_back(x);
        day_of_year = 9'(doy);
`ifdef DOY_LEAP_YEAR_EN
        leap_year = lp;
`endif
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_result();
    endtask

    initial begin
        exp_t x;
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_month", int'(month), 0);
        chk("rst_day", int'(day), 0);
        chk("rst_err", int'(err), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        issue(1,   1'b0, 1,  1,  0, 1);
        issue(365, 1'b0, 12, 31, 0, 12);
        issue(59,  1'b0, 2,  28, 0, 2);
        issue(60,  1'b0, 3,  1,  0, 3);
        issue(31,  1'b0, 1,  31, 0, 1);
        issue(100, 1'b0, 4,  10, 0, 4);
        issue(0,   1'b0, 0,  0,  1, 0);
        issue(366, 1'b0, 0,  0,  1, 0);
        issue(334, 1'b0, 11, 30, 0, 11);
`ifdef DOY_LEAP_YEAR_EN
        issue(60,  1'b1, 2,  29, 0, 2);
        issue(366, 1'b1, 12, 31, 0, 12);
        issue(61,  1'b1, 3,  1,  0, 3);
        issue(367, 1'b1, 0,  0,  1, 0);
        issue(60,  1'b0, 3,  1,  0, 3);
`endif

        // Second start two cycles into a conversion must be dropped.
        @(negedge clk);
        wait_idle();
        x.m = 7; x.d = 19; x.e = 0; x.c = cyc + 1 + 7;
        q.push_back(x);
        day_of_year = 9'd200;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_accept", int'(busy), 1);
        @(negedge clk);
        day_of_year = 9'd10;
        start = 1'b1;
        chk("busy_before_ignored", int'(busy), 1);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("busy_throughout", int'(busy), 1);
            @(negedge clk);
        end
        wait_result();

        // Reset mid-conversion aborts without a done.
        @(negedge clk);
        wait_idle();
        day_of_year = 9'd300;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("busy_before_abort", int'(busy), 1);
        rst = 1'b1;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_month", int'(month), 0);
        chk("abort_day", int'(day), 0);
        chk("abort_err", int'(err), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (12) begin
            @(negedge clk);
            chk("no_done_after_abort", int'(done), 0);
        end
        issue(32, 1'b0, 2, 1, 0, 2);

        repeat (3) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
